// File: rtl/noc_pkg.sv
// Shared router definitions: flit type codes, the type field width,
// one-hot mux select constants and the packet arbiter state encoding.
package noc_pkg;

    // Flit type field occupies the top bits of every flit.
    localparam int unsigned TYPEW = 2;

    localparam logic [1:0] FLIT_NONE = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;
    localparam logic [1:0] FLIT_DATA = 2'b11;

    // One-hot select for the 2:1 flit mux; bit0 = input 0, bit1 = input 1.
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_0    = 2'b01;
    localparam logic [1:0] SEL_1    = 2'b10;

    typedef enum logic {
        StIdle,
        StLock
    } arb_state_e;

    // Select code for a single input index.
    function automatic logic [1:0] sel_of(input logic idx);
        return idx ? SEL_1 : SEL_0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-requester round-robin picker. rr names the preferred
// requester when both request; a lone requester always wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       rr_i,
    output logic [1:0] gnt_o
);
    import noc_pkg::*;

    // Pick the preferred requester on contention, else whoever requests.
    always_comb begin
        gnt_o = SEL_NONE;
        unique case (req_i)
            2'b01:   gnt_o = SEL_0;
            2'b10:   gnt_o = SEL_1;
            2'b11:   gnt_o = sel_of(rr_i);
            default: gnt_o = SEL_NONE;
        endcase
    end

endmodule

// File: rtl/mux_pkt_arbiter.sv
// Packet-level round-robin arbiter for the router output 2:1 flit mux.
// Holds a grant from HEAD to TAIL so packets never interleave, acks the
// granted input on downstream readiness, and force-releases a granted
// input that stays idle for TIMEOUT cycles.
module mux_pkt_arbiter #(
    parameter int unsigned TYPEW   = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNTW    = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             ordy,
    output logic [1:0]       sel,
    output logic             iack_0,
    output logic             iack_1,
    output logic             busy,
    output logic [CNTW-1:0]  flit_cnt,
    output logic             err_type,
    output logic             err_tmo
);
    import noc_pkg::*;

    localparam logic [TYPEW-1:0] TyHead = TYPEW'(FLIT_HEAD);
    localparam logic [TYPEW-1:0] TyTail = TYPEW'(FLIT_TAIL);
    localparam logic [TYPEW-1:0] TyData = TYPEW'(FLIT_DATA);
    localparam logic [CNTW-1:0]  TmoVal = CNTW'(TIMEOUT);
    localparam logic [CNTW-1:0]  CntMax = '1;

    arb_state_e      state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic            rr_q, rr_d;
    logic [CNTW-1:0] wdog_q, wdog_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_type_q, err_type_d;
    logic            err_tmo_q, err_tmo_d;

    logic [1:0]       head_req;
    logic [1:0]       bad_req;
    logic [1:0]       pick_gnt;
    logic             gidx;
    logic             vld_g;
    logic [TYPEW-1:0] typ_g;
    logic             head_other;
    logic             xfer;
    logic [CNTW-1:0]  wdog_inc;

    // Per-input request decode: HEADs request, stray DATA/TAIL are errors in idle.
    always_comb begin
        head_req[0] = ivalid_0 && (itype_0 == TyHead);
        head_req[1] = ivalid_1 && (itype_1 == TyHead);
        bad_req[0]  = ivalid_0 && ((itype_0 == TyData) || (itype_0 == TyTail));
        bad_req[1]  = ivalid_1 && ((itype_1 == TyData) || (itype_1 == TyTail));
    end

    rr_pick2 u_pick (
        .req_i (head_req),
        .rr_i  (rr_q),
        .gnt_o (pick_gnt)
    );

    // Granted-input view; only meaningful while locked (sel_q one-hot).
    always_comb begin
        gidx       = sel_q[1];
        vld_g      = gidx ? ivalid_1 : ivalid_0;
        typ_g      = gidx ? itype_1 : itype_0;
        head_other = gidx ? head_req[0] : head_req[1];
        xfer       = (state_q == StLock) && vld_g && ordy;
        wdog_inc   = wdog_q + CNTW'(1);
    end

    // Next-state: grant, packet tracking, back-to-back handover and watchdog.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        wdog_d     = wdog_q;
        cnt_d      = cnt_q;
        err_type_d = 1'b0;
        err_tmo_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A HEAD is never flagged, so "ungranted" reduces to any stray flit.
                err_type_d = |bad_req;
                if (pick_gnt != SEL_NONE) begin
                    state_d = StLock;
                    sel_d   = pick_gnt;
                    cnt_d   = '0;
                    wdog_d  = '0;
                end
            end
            StLock: begin
                if (vld_g) begin
                    // Any presented flit, even when stalled by ordy, keeps the watchdog quiet.
                    wdog_d = '0;
                    if (xfer) begin
                        if (cnt_q != CntMax) begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                        if (typ_g == TyTail) begin
                            rr_d = ~gidx;
                            if (head_other) begin
                                // Hand over without an idle bubble.
                                sel_d = sel_of(~gidx);
                                cnt_d = '0;
                            end else begin
                                state_d = StIdle;
                                sel_d   = SEL_NONE;
                            end
                        end
                    end
                end else if (wdog_inc == TmoVal) begin
                    state_d   = StIdle;
                    sel_d     = SEL_NONE;
                    rr_d      = ~gidx;
                    wdog_d    = '0;
                    err_tmo_d = 1'b1;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = SEL_NONE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= StIdle;
            sel_q      <= SEL_NONE;
            rr_q       <= 1'b0;
            wdog_q     <= '0;
            cnt_q      <= '0;
            err_type_q <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            wdog_q     <= wdog_d;
            cnt_q      <= cnt_d;
            err_type_q <= err_type_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    // Outputs: acks are combinational on the granted input only.
    always_comb begin
        sel      = sel_q;
        busy     = (state_q == StLock);
        iack_0   = xfer && !gidx;
        iack_1   = xfer && gidx;
        flit_cnt = cnt_q;
        err_type = err_type_q;
        err_tmo  = err_tmo_q;
    end

endmodule
